// File: rtl/pn_checker.sv
// Self-synchronising checker for the 4-stage PN stream s[n+4] = s[n+1] ^ s[n].
// Hunts for alignment, verifies it, then flywheels a local predictor to count bit errors.
module pn_checker #(
    parameter int LOCK_CNT = 8,
    parameter int LOSS_WIN = 16,
    parameter int LOSS_THR = 4,
    parameter int ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             din,
    input  logic             clr,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_VERIFY = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [7:0]       LOCK_CNT_C = 8'(LOCK_CNT);
    localparam logic [7:0]       WIN_LAST_C = 8'(LOSS_WIN - 1);
    localparam logic [7:0]       LOSS_THR_C = 8'(LOSS_THR);
    localparam logic [ERR_W-1:0] ERR_MAX_C  = {ERR_W{1'b1}};
    localparam logic [ERR_W-1:0] ERR_ONE_C  = {{(ERR_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic [3:0]       hist_q, hist_d;
    logic [2:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [7:0]       win_bits_q, win_bits_d;
    logic [7:0]       win_err_q, win_err_d;
    logic             locked_q, locked_d;
    logic             err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic             exp_s;
    logic             mis_s;
    logic [3:0]       shift_din_s;
    logic [7:0]       match_inc_s;
    logic [7:0]       win_err_inc_s;

    // Next-state logic for the hunt / verify / flywheel sequencer and its counters.
    always_comb begin
        state_d       = state_q;
        hist_d        = hist_q;
        fill_d        = fill_q;
        match_d       = match_q;
        win_bits_d    = win_bits_q;
        win_err_d     = win_err_q;
        err_pulse_d   = 1'b0;
        exp_s         = hist_q[2] ^ hist_q[3];
        mis_s         = din ^ exp_s;
        shift_din_s   = {hist_q[2:0], din};
        match_inc_s   = match_q + 8'd1;
        win_err_inc_s = win_err_q + {7'd0, mis_s};

        if (en) begin
            case (state_q)
                ST_HUNT: begin
                    hist_d = shift_din_s;
                    fill_d = fill_q + 3'd1;
                    if (fill_q == 3'd3) begin
                        state_d = ST_VERIFY;
                        match_d = 8'd0;
                    end else begin
                        state_d = ST_HUNT;
                    end
                end
                ST_VERIFY: begin
                    hist_d = shift_din_s;
                    if (mis_s) begin
                        match_d = 8'd0;
                    end else if (match_inc_s == LOCK_CNT_C) begin
                        // An all-zero history is the stuck-at-0 line, never a PN phase.
                        match_d = 8'd0;
                        if (shift_din_s != 4'b0000) begin
                            state_d    = ST_LOCKED;
                            win_bits_d = 8'd0;
                            win_err_d  = 8'd0;
                        end else begin
                            state_d = ST_VERIFY;
                        end
                    end else begin
                        match_d = match_inc_s;
                    end
                end
                ST_LOCKED: begin
                    hist_d      = {hist_q[2:0], exp_s};
                    err_pulse_d = mis_s;
                    if (win_err_inc_s >= LOSS_THR_C) begin
                        state_d    = ST_HUNT;
                        fill_d     = 3'd0;
                        win_bits_d = 8'd0;
                        win_err_d  = 8'd0;
                    end else if (win_bits_q == WIN_LAST_C) begin
                        win_bits_d = 8'd0;
                        win_err_d  = 8'd0;
                    end else begin
                        win_bits_d = win_bits_q + 8'd1;
                        win_err_d  = win_err_inc_s;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    fill_d  = 3'd0;
                    match_d = 8'd0;
                end
            endcase
        end else begin
            err_pulse_d = 1'b0;
        end

        // Clear beats a simultaneous error; the pulse above is unaffected.
        if (clr) begin
            err_count_d = {ERR_W{1'b0}};
        end else if (en && (state_q == ST_LOCKED) && mis_s && (err_count_q != ERR_MAX_C)) begin
            err_count_d = err_count_q + ERR_ONE_C;
        end else begin
            err_count_d = err_count_q;
        end

        locked_d = (state_d == ST_LOCKED);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            hist_q      <= 4'b0000;
            fill_q      <= 3'd0;
            match_q     <= 8'd0;
            win_bits_q  <= 8'd0;
            win_err_q   <= 8'd0;
            locked_q    <= 1'b0;
            err_pulse_q <= 1'b0;
            err_count_q <= {ERR_W{1'b0}};
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_bits_q  <= win_bits_d;
            win_err_q   <= win_err_d;
            locked_q    <= locked_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_pn_checker.sv
// Bench for pn_checker: a phase-tracking reference model checked every cycle,
// plus directed literal expectations for lock timing, loss, clear and saturation.
module tb_pn_checker;

    localparam int LOCK_CNT = 8;
    localparam int LOSS_WIN = 16;
    localparam int LOSS_THR = 4;
    localparam int M_HUNT   = 0;
    localparam int M_VERIFY = 1;
    localparam int M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        din = 1'b0;
    logic        clr = 1'b0;
    logic        locked, err_pulse;
    logic [15:0] err_count;
    logic        locked4, err_pulse4;
    logic [3:0]  err_count4;

    pn_checker u_dut (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
    );

    pn_checker #(.ERR_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
        .locked(locked4), .err_pulse(err_pulse4), .err_count(err_count4)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    // Source stream and reference model state
    bit pn[15];
    int gi = 0;
    int vc = 0;
    int m_state, m_fill, m_run, m_ph, m_slot, m_werr, m_cnt16, m_cnt4;
    bit m_locked, m_pulse;
    bit h[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_state = M_HUNT; m_fill = 0; m_run = 0; m_ph = 0; m_slot = 0; m_werr = 0;
        m_cnt16 = 0; m_cnt4 = 0; m_locked = 1'b0; m_pulse = 1'b0;
        h.delete();
    endtask

    // Next PN index following the last four received bits, found by table search.
    function automatic int find_phase();
        for (int k = 0; k < 15; k++) begin
            if (pn[k] == h[0] && pn[(k+1)%15] == h[1] && pn[(k+2)%15] == h[2] && pn[(k+3)%15] == h[3])
                return (k + 4) % 15;
        end
        return 0;
    endfunction

    task automatic model_step(input bit e, input bit d, input bit c);
        bit pred, err, any_one;
        m_pulse = 1'b0;
        if (e) begin
            if (m_state == M_HUNT) begin
                h.push_back(d);
                if (h.size() > 4) void'(h.pop_front());
                m_fill++;
                if (m_fill == 4) begin m_state = M_VERIFY; m_run = 0; end
            end else if (m_state == M_VERIFY) begin
                pred = h[0] ^ h[1];
                h.push_back(d);
                void'(h.pop_front());
                m_run = (d == pred) ? m_run + 1 : 0;
                if (m_run == LOCK_CNT) begin
                    m_run = 0;
                    any_one = h[0] | h[1] | h[2] | h[3];
                    if (any_one) begin
                        m_state = M_LOCKED; m_ph = find_phase(); m_slot = 0; m_werr = 0;
                    end
                end
            end else begin
                pred = pn[m_ph];
                m_ph = (m_ph + 1) % 15;
                err = (d != pred);
                m_pulse = err;
                if (err) begin
                    m_werr++;
                    if (m_cnt16 < 65535) m_cnt16++;
                    if (m_cnt4 < 15) m_cnt4++;
                end
                if (m_werr >= LOSS_THR) begin
                    m_state = M_HUNT; m_fill = 0; m_slot = 0; m_werr = 0; h.delete();
                end else if (m_slot == LOSS_WIN - 1) begin
                    m_slot = 0; m_werr = 0;
                end else begin
                    m_slot++;
                end
            end
        end
        if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
        m_locked = (m_state == M_LOCKED);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("locked", int'(locked), int'(m_locked));
            chk("err_pulse", int'(err_pulse), int'(m_pulse));
            chk("err_count", int'(err_count), m_cnt16);
            chk("locked_w4", int'(locked4), int'(m_locked));
            chk("err_pulse_w4", int'(err_pulse4), int'(m_pulse));
            chk("err_count_w4", int'(err_count4), m_cnt4);
        end
    end

    task automatic step_bit(input bit e, input bit d, input bit c);
        en = e; din = d; clr = c;
        @(posedge clk);
        model_step(e, d, c);
        @(negedge clk);
    endtask

    task automatic step(input bit e, input bit flip, input bit c);
        bit b;
        b = pn[gi % 15];
        if (e) begin
            step_bit(1'b1, b ^ flip, c);
            gi++;
            vc++;
        end else begin
            step_bit(1'b0, 1'($urandom_range(0, 1)), c);
        end
    endtask

    task automatic do_rst();
        #2;
        rst = 1'b1;
        m_reset();
        #1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_pulse", int'(err_pulse), 0);
        chk("rst_count", int'(err_count), 0);
        chk("rst_count_w4", int'(err_count4), 0);
        @(negedge clk);
        rst = 1'b0;
        vc = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int iter;
        bit e, f, c;
        pn[0] = 1'b1; pn[1] = 1'b1; pn[2] = 1'b0; pn[3] = 1'b1;
        for (int n = 4; n < 15; n++) pn[n] = pn[n-3] ^ pn[n-4];
        m_reset();
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_locked", int'(locked), 0);
        chk("reset_count", int'(err_count), 0);
        rst = 1'b0;
        gi = 0; vc = 0;

        // Clean stream from the generator seed: lock after bit index 11
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 10) chk("lock_not_yet", int'(locked), 0);
            if (i == 11) chk("lock_at_11", int'(locked), 1);
        end
        chk("clean_count", int'(err_count), 0);

        // Single flipped bit while locked
        step(1'b1, 1'b1, 1'b0);
        chk("single_pulse", int'(err_pulse), 1);
        chk("single_count", int'(err_count), 1);
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 0) chk("single_pulse_off", int'(err_pulse), 0);
        end
        chk("flywheel_locked", int'(locked), 1);
        chk("flywheel_count", int'(err_count), 1);

        // Clear with en low
        step(1'b0, 1'b0, 1'b1);
        chk("clr_idle", int'(err_count), 0);

        // Four errors in one window force loss, then relock 12 valid bits later
        for (int k = 0; k < 4; k++) begin
            step(1'b1, 1'b1, 1'b0);
            chk("loss_locked", int'(locked), (k < 3) ? 1 : 0);
        end
        chk("loss_count", int'(err_count), 4);
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == 10) chk("relock_not_yet", int'(locked), 0);
            if (i == 11) chk("relock_at_12", int'(locked), 1);
        end

        // Reset mid-lock, then an all-zero line must never lock
        do_rst();
        for (int i = 0; i < 64; i++) begin
            step_bit(1'b1, 1'b0, 1'b0);
            chk("zero_no_lock", int'(locked), 0);
        end
        chk("zero_count", int'(err_count), 0);

        // Relock, then 3 errors per 16-bit window for 6 windows
        iter = 0;
        while (!m_locked && iter < 60) begin
            step(1'b1, 1'b0, 1'b0);
            iter++;
        end
        chk("sat_relock", int'(locked), 1);
        for (int j = 0; j < 96; j++) begin
            f = ((j % 16) == 2) || ((j % 16) == 6) || ((j % 16) == 10);
            step(1'b1, f, 1'b0);
        end
        chk("sat_locked", int'(locked4), 1);
        chk("sat_count_w4", int'(err_count4), 15);
        chk("sat_count_w16", int'(err_count), 18);

        // Random en gaps, clear colliding with an error, lock measured in valid bits
        do_rst();
        iter = 0;
        while (vc < 60 && iter < 1000) begin
            e = 1'($urandom_range(0, 1));
            f = e && (vc == 20 || vc == 30 || vc == 40);
            c = e && (vc == 30);
            step(e, f, c);
            if (e && vc == 11) chk("gap_lock_not_yet", int'(locked), 0);
            if (e && vc == 12) chk("gap_lock_at_12", int'(locked), 1);
            if (e && vc == 21) chk("gap_err_count", int'(err_count), 1);
            if (e && vc == 31) begin
                chk("clr_err_pulse", int'(err_pulse), 1);
                chk("clr_wins", int'(err_count), 0);
            end
            if (e && vc == 41) chk("after_clr_count", int'(err_count), 1);
            iter++;
        end
        chk("gap_budget", (vc >= 60) ? 1 : 0, 1);
        chk("gap_locked_end", int'(locked), 1);
        do_rst();
        step(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pn_checker.md
# pn_checker

Serial PN sequence checker that receives the bit stream produced by the 4-stage PN generator. The generator uses the recurrence s[n+4] = s[n+1] ^ s[n], so the stream has period 15. The checker self-synchronizes to the incoming stream, declares lock, and then free-runs a local predictor to count bit errors. It sits at the receive end of the test path, after the Hamming decoder, and provides the BER measurement for that path.

## Interface
- LOCK_CNT, 8: consecutive correct predictions needed to declare lock (range 1..255).
- LOSS_WIN, 16: length, in valid bits, of the loss-of-lock observation window (range 2..255).
- LOSS_THR, 4: errors within one window that force loss of lock (range 1..LOSS_WIN).
- ERR_W, 16: width of the error counter.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset: asynchronous, active-high.
- en  in  1  din valid this cycle; when low, no state advances.
- din  in  1  received PN bit.
- clr  in  1  synchronous clear of err_count; takes effect in any state, regardless of en.
- locked  out  1  high while in LOCKED.
- err_pulse  out  1  one-cycle flag: the last valid bit mismatched while LOCKED.
- err_count  out  ERR_W  saturating count of errors detected while LOCKED.

## Operation
- hist[3:0] holds the last 4 bits; hist[0] is the newest.
- Expected bit: exp = hist[2] ^ hist[3].
- State machine, encoding free:
  - HUNT
    - Each valid bit: shift din into hist and increment fill (0..4).
    - When fill reaches 4: go to VERIFY with match = 0.
  - VERIFY
    - Each valid bit: shift din into hist.
    - din == exp: match++.
    - din != exp: match = 0. Stay in VERIFY; the history now contains the received bit, so resynchronization continues.
    - When match reaches LOCK_CNT: go to LOCKED, but only if the post-shift hist != 4'b0000.
    - If hist is all zero at that point, clear match and stay in VERIFY. This stops the checker locking on an all-zero or stuck-at-0 line.
  - LOCKED (flywheel)
    - Each valid bit: shift exp, not din, into hist, so channel errors never corrupt the predictor.
    - din != exp: err_pulse = 1 next cycle; err_count++ (saturates at all-ones); win_err++.
    - win_bits counts valid bits from 0 to LOSS_WIN-1 and then wraps. On wrap, win_err clears.
    - When win_err reaches LOSS_THR (evaluated including the current bit): go to HUNT, set fill = 0, and clear win_bits and win_err. err_count keeps its value.
- Errors are counted only in LOCKED. Mismatches in HUNT or VERIFY never touch err_count or err_pulse.
- If clr and an error occur in the same cycle, clr wins: err_count = 0 and the error is not counted. err_pulse still fires.

## Timing
- Reset values:
  - state = HUNT.
  - hist, fill, match, win_bits, win_err = 0.
  - locked = 0, err_pulse = 0, err_count = 0.
- All outputs are registered.
- locked rises in the cycle after the edge that samples the LOCK_CNT-th consecutive matching bit. From reset, with a clean stream and en held high, that bit is bit index 4+LOCK_CNT-1 (index 11 for the default LOCK_CNT).
- locked falls in the cycle after the edge that samples the LOSS_THR-th error in a window.
- err_pulse is high for exactly one cycle, one cycle after the erroneous bit is sampled. It is 0 on any cycle where the previous cycle had en = 0.
- When en = 0: state, hist and counters hold. Only clr acts.
- Reset asserted mid-operation returns every register to its reset value immediately (asynchronous), with no partial update.

## Test plan
- Clean generator stream (reset seed 1,1,0,1; sequence 1101 0111 1000 100…), en held high → locked = 1 starting the cycle after bit index 11; err_count stays 0 over 100 bits.
- After lock, flip one bit → err_pulse for 1 cycle, err_count = 1, locked stays high, and no further errors on the following 15 bits (flywheel holds).
- After lock, flip 4 bits within one 16-bit window → locked drops after the 4th flip; err_count = 4; the checker relocks 12 valid bits later on a clean stream.
- All-zero din for 64 bits → locked never rises; err_count = 0.
- ERR_W = 4, 3 flips per 16-bit window for 6 windows → locked stays high; err_count saturates at 15.
- en toggled pseudo-randomly, with clr pulsed together with an error, and rst asserted mid-LOCKED → identical lock and error results at equal valid-bit counts; clr leaves err_count = 0; rst gives all outputs 0 immediately.
